bg_capture: RTL and testbench

BG_CAPTURE -- requirements
Module: bg_capture

---
 rtl/vga_pkg.sv | 19 +
 rtl/vga_if.sv | 19 +
 rtl/bg_capture.sv | 133 +++++++++++++
 tb/tb_bg_capture.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, background-capture defaults and the
// capture FSM state encoding.
package vga_pkg;

  localparam int HOR_PIXELS     = 1024;
  localparam int VER_PIXELS     = 768;

  // Default downscale (log2 per axis) and background memory row pitch.
  localparam int BG_SCALE_SHIFT = 2;
  localparam int BG_ROW_STRIDE  = 256;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_ARMED   = 2'd1,
    CAP_CAPTURE = 2'd2,
    CAP_DONE    = 2'd3
  } capture_state_t;

endpackage

// File: rtl/vga_if.sv
// Pixel stream bundle: timing counters, sync/blanking and RGB444 colour.
// The stream carries no valid/ready: every clock presents exactly one pixel
// and a pixel is "valid" only when both hblnk and vblnk are low.
interface vga_if;

  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  // Source side (timing generator / test driver).
  modport master (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  // Sink side (consumers such as the background capture).
  modport vga_in (input vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);

endinterface

// File: rtl/bg_capture.sv
// Background frame capture: on request, waits for the next frame start and
// writes one downscaled frame of RGB444 pixels into the background RAM.
// wr_en is a single-cycle write strobe with no backpressure: the RAM must
// accept every cycle in which wr_en is high, using wr_addr/wr_data of that
// same cycle.
module bg_capture
  import vga_pkg::*;
#(
  parameter int SCALE_SHIFT = BG_SCALE_SHIFT,
  parameter int ROW_STRIDE  = BG_ROW_STRIDE
) (
  input  logic           clk,
  input  logic           rst,
  vga_if.vga_in          vga_in,
  input  logic           capture_req,
  output logic           busy,
  output logic           done,
  output logic           wr_en,
  output logic [19:0]    wr_addr,
  output logic [11:0]    wr_data,
  output logic [15:0]    words_written,
  output capture_state_t state_dbg
);

  // Low counter bits that must be zero for a pixel to sit on the sample grid.
  localparam logic [10:0] LOW_MASK    = 11'((1 << SCALE_SHIFT) - 1);
  localparam logic [19:0] STRIDE_BITS = 20'(ROW_STRIDE);
  // Address of the final word of a frame; its write ends the capture.
  localparam logic [19:0] LAST_ADDR   =
    20'(((VER_PIXELS >> SCALE_SHIFT) * ROW_STRIDE) - 1);

  // Scaled row times the stride, built from shifted partial sums so any
  // stride value maps to adders only.
  function automatic logic [19:0] scaled_addr(input logic [10:0] v,
                                              input logic [10:0] h);
    logic [19:0] row;
    logic [19:0] acc;
    row = 20'(v >> SCALE_SHIFT);
    acc = 20'(h >> SCALE_SHIFT);
    for (int i = 0; i < 20; i++) begin
      if (STRIDE_BITS[i]) acc = acc + (row << i);
    end
    return acc;
  endfunction

  capture_state_t state_q, state_d;
  logic           wr_en_q, wr_en_d;
  logic [19:0]    wr_addr_q, wr_addr_d;
  logic [11:0]    wr_data_q, wr_data_d;
  logic [15:0]    words_q, words_d;

  logic pix_active;
  logic pix_on_grid;
  logic frame_start;
  logic candidate;
  logic last_issued;

  // Sync levels play no part in frame alignment.
  logic unused_sync;
  assign unused_sync = vga_in.vsync ^ vga_in.hsync;

  // Qualify the current pixel and detect the final write of the frame.
  always_comb begin
    pix_active  = !vga_in.hblnk && !vga_in.vblnk;
    pix_on_grid = ((vga_in.hcount & LOW_MASK) == 11'd0) &&
                  ((vga_in.vcount & LOW_MASK) == 11'd0);
    frame_start = pix_active && (vga_in.hcount == 11'd0) &&
                  (vga_in.vcount == 11'd0);
    last_issued = wr_en_q && (wr_addr_q == LAST_ADDR);
    candidate   = pix_active && pix_on_grid &&
                  (((state_q == CAP_CAPTURE) && !last_issued) ||
                   ((state_q == CAP_ARMED) && frame_start));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= CAP_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CAP_IDLE:    if (capture_req) state_d = CAP_ARMED;
      CAP_ARMED:   if (frame_start) state_d = CAP_CAPTURE;
      CAP_CAPTURE: if (last_issued) state_d = CAP_DONE;
      CAP_DONE:    state_d = CAP_IDLE;
      default:     state_d = CAP_IDLE;
    endcase
  end

  // Write datapath: one registered write per candidate pixel.
  always_comb begin
    wr_en_d   = candidate;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    words_d   = words_q;
    if (candidate) begin
      wr_addr_d = scaled_addr(vga_in.vcount, vga_in.hcount);
      wr_data_d = vga_in.rgb;
      words_d   = words_q + 16'd1;
    end
    if ((state_q == CAP_IDLE) && capture_req) words_d = '0;
  end

  // Write datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      words_q   <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      words_q   <= words_d;
    end
  end

  // Outputs decoded from the state and datapath registers.
  always_comb begin
    busy          = (state_q == CAP_ARMED) || (state_q == CAP_CAPTURE);
    done          = (state_q == CAP_DONE);
    wr_en         = wr_en_q;
    wr_addr       = wr_addr_q;
    wr_data       = wr_data_q;
    words_written = words_q;
    state_dbg     = state_q;
  end

endmodule

// File: tb/tb_bg_capture.sv
// Testbench for bg_capture: directed pixel vectors, an expected-write queue
// filled by the driver and drained by an independent write monitor.
module tb_bg_capture;
  import vga_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic capture_req = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           busy;
  logic           done;
  logic           wr_en;
  logic [19:0]    wr_addr;
  logic [11:0]    wr_data;
  logic [15:0]    words_written;
  capture_state_t state_dbg;

  vga_if vif ();

  bg_capture dut (
    .clk           (clk),
    .rst           (rst),
    .vga_in        (vif),
    .capture_req   (capture_req),
    .busy          (busy),
    .done          (done),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .words_written (words_written),
    .state_dbg     (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  // Entry layout: {due cycle[31:0], addr[19:0], data[11:0]}
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  int          n_checks = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  int unsigned done_cyc = 0;
  int unsigned last_wr_cyc = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  name, act, act, exp, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Applies one pixel (plus rst/capture_req) for one clock; pushes the
  // expected write, due one cycle after the pixel is sampled.
  task automatic drive(input logic r, input logic req, input int h,
                       input int v, input logic hb, input logic vb,
                       input logic [11:0] rgb, input logic exp_wr,
                       input int exp_addr);
    @(negedge clk);
    rst         = r;
    capture_req = req;
    vif.hcount  = 11'(h);
    vif.vcount  = 11'(v);
    vif.hblnk   = hb;
    vif.vblnk   = vb;
    vif.rgb     = rgb;
    vif.hsync   = ~vif.hsync;
    vif.vsync   = (v >= 770) && (v < 772);
    if (exp_wr) exp_q.push_back({cyc + 32'd1, 20'(exp_addr), rgb});
  endtask

  task automatic blank(input int n, input logic r, input logic req);
    repeat (n) drive(r, req, 1100, 10, 1'b1, 1'b0, 12'h000, 1'b0, 0);
  endtask

  // Issues the frame's last grid pixel and checks the done pulse timing.
  task automatic finish_capture(input string name, input int exp_words);
    int d0;
    d0 = done_cnt;
    drive(0, 0, 1020, 764, 1'b0, 1'b0, 12'h7E7, 1'b1, 49151);
    blank(4, 0, 0);
    check({name, "_done_once"}, done_cnt, d0 + 1);
    check({name, "_done_after_last_write"}, done_cyc, last_wr_cyc + 1);
    check({name, "_words"}, words_written, exp_words);
    check({name, "_back_to_idle"}, state_dbg, CAP_IDLE);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (wr_en !== 1'b0) begin
      last_wr_cyc = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: cyc %0d addr %0d data %h, required no write",
                 cyc, wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({cyc, wr_addr, wr_data} === mon_e) n_pass++;
        else $display("FAIL write: got cyc %0d addr %0d data %h, required cyc %0d addr %0d data %h",
                      cyc, wr_addr, wr_data, mon_e[63:32], mon_e[31:12], mon_e[11:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    vif.hcount = '0;
    vif.vcount = '0;
    vif.hblnk  = 1'b1;
    vif.vblnk  = 1'b0;
    vif.rgb    = '0;
    vif.hsync  = 1'b0;
    vif.vsync  = 1'b0;

    // Reset held 3 cycles during active video; request asserted with rst.
    drive(1, 0, 0, 8, 1'b0, 1'b0, 12'h111, 1'b0, 0);
    drive(1, 0, 4, 8, 1'b0, 1'b0, 12'h222, 1'b0, 0);
    drive(1, 1, 8, 8, 1'b0, 1'b0, 12'h333, 1'b0, 0);
    blank(1, 0, 0);
    check("rst_state", state_dbg, CAP_IDLE);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_words", words_written, 0);
    blank(1, 0, 0);
    check("rst_beats_req", state_dbg, CAP_IDLE);

    // Address map and blanking inside one capture.
    drive(0, 1, 1100, 10, 1'b1, 1'b0, 12'h000, 1'b0, 0);
    drive(0, 0, 4, 300, 1'b0, 1'b0, 12'h5A5, 1'b0, 0);
    check("armed_state", state_dbg, CAP_ARMED);
    check("armed_busy", busy, 1);
    drive(0, 0, 0, 0, 1'b1, 1'b0, 12'h5A5, 1'b0, 0);
    drive(0, 0, 0, 4, 1'b0, 1'b0, 12'h5A5, 1'b0, 0);
    check("armed_waits", state_dbg, CAP_ARMED);
    drive(0, 0, 0, 0, 1'b0, 1'b0, 12'h000, 1'b1, 0);
    drive(0, 0, 8, 4, 1'b0, 1'b0, 12'hABC, 1'b1, 258);
    check("entry_state", state_dbg, CAP_CAPTURE);
    drive(0, 0, 9, 4, 1'b0, 1'b0, 12'hFFF, 1'b0, 0);
    drive(0, 0, 8, 5, 1'b0, 1'b0, 12'hFFF, 1'b0, 0);
    drive(0, 0, 1024, 4, 1'b1, 1'b0, 12'hFFF, 1'b0, 0);
    drive(0, 0, 1100, 8, 1'b1, 1'b0, 12'hFFF, 1'b0, 0);
    drive(0, 0, 1340, 8, 1'b1, 1'b0, 12'hFFF, 1'b0, 0);
    drive(0, 0, 1343, 8, 1'b1, 1'b0, 12'hFFF, 1'b0, 0);
    drive(0, 0, 0, 768, 1'b0, 1'b1, 12'hFFF, 1'b0, 0);
    drive(0, 0, 4, 800, 1'b0, 1'b1, 12'hFFF, 1'b0, 0);
    drive(0, 0, 1024, 804, 1'b1, 1'b1, 12'hFFF, 1'b0, 0);
    drive(0, 0, 1343, 805, 1'b1, 1'b1, 12'hFFF, 1'b0, 0);
    check("map_words", words_written, 2);
    check("map_still_capture", state_dbg, CAP_CAPTURE);
    finish_capture("map", 3);

    // Full frame: request mid-frame at vcount=300, capture next frame.
    d0 = done_cnt;
    drive(0, 1, 500, 300, 1'b0, 1'b0, 12'h123, 1'b0, 0);
    drive(0, 0, 504, 300, 1'b0, 1'b0, 12'h123, 1'b0, 0);
    check("full_armed", state_dbg, CAP_ARMED);
    check("full_words_cleared", words_written, 0);
    drive(0, 0, 0, 304, 1'b0, 1'b0, 12'h123, 1'b0, 0);
    for (int v = 0; v < 768; v += 4) begin
      for (int h = 0; h < 1024; h += 4) begin
        drive(0, 0, h, v, 1'b0, 1'b0, 12'(((v * 5) + (h * 3)) ^ (h >> 4)),
              1'b1, ((v / 4) * 256) + (h / 4));
      end
      drive(0, 0, 1024, v, 1'b1, 1'b0, 12'hFFF, 1'b0, 0);
    end
    blank(3, 0, 0);
    check("full_words", words_written, 49152);
    check("full_done_once", done_cnt, d0 + 1);
    check("full_done_after_last_write", done_cyc, last_wr_cyc + 1);
    check("full_idle", state_dbg, CAP_IDLE);
    check("full_last_addr", wr_addr, 49151);

    // Reset in the middle of a capture at vcount=100.
    d0 = done_cnt;
    drive(0, 1, 1100, 10, 1'b1, 1'b0, 12'h000, 1'b0, 0);
    drive(0, 0, 0, 0, 1'b0, 1'b0, 12'h0F0, 1'b1, 0);
    drive(0, 0, 0, 100, 1'b0, 1'b0, 12'h00F, 1'b1, 6400);
    drive(1, 0, 4, 100, 1'b0, 1'b0, 12'hF00, 1'b0, 0);
    drive(0, 0, 8, 100, 1'b0, 1'b0, 12'hF00, 1'b0, 0);
    check("midrst_wr_en", wr_en, 0);
    check("midrst_state", state_dbg, CAP_IDLE);
    check("midrst_words", words_written, 0);
    drive(0, 0, 12, 100, 1'b0, 1'b0, 12'hF00, 1'b0, 0);
    blank(3, 0, 0);
    check("midrst_no_done", done_cnt, d0);
    drive(0, 1, 200, 100, 1'b0, 1'b0, 12'h111, 1'b0, 0);
    drive(0, 0, 204, 100, 1'b0, 1'b0, 12'h111, 1'b0, 0);
    drive(0, 0, 0, 0, 1'b0, 1'b0, 12'h9C3, 1'b1, 0);
    drive(0, 0, 4, 0, 1'b0, 1'b0, 12'h3C9, 1'b1, 1);
    blank(1, 0, 0);
    check("recap_words", words_written, 2);
    check("recap_state", state_dbg, CAP_CAPTURE);
    finish_capture("recap", 3);

    // Request held high across two frames.
    d0 = done_cnt;
    blank(1, 0, 1);
    drive(0, 1, 0, 0, 1'b0, 1'b0, 12'hC0C, 1'b1, 0);
    drive(0, 1, 1020, 764, 1'b0, 1'b0, 12'h0C0, 1'b1, 49151);
    blank(1, 0, 1);
    check("b2b_busy_last_write", busy, 1);
    blank(1, 0, 1);
    check("b2b_done_state", state_dbg, CAP_DONE);
    check("b2b_done_pulse", done, 1);
    check("b2b_busy_in_done", busy, 0);
    blank(1, 0, 1);
    check("b2b_idle_state", state_dbg, CAP_IDLE);
    check("b2b_busy_in_idle", busy, 0);
    blank(1, 0, 1);
    check("b2b_rearmed", state_dbg, CAP_ARMED);
    check("b2b_busy_again", busy, 1);
    check("b2b_done_once", done_cnt, d0 + 1);
    drive(0, 1, 4, 8, 1'b0, 1'b0, 12'h777, 1'b0, 0);
    drive(0, 1, 0, 0, 1'b0, 1'b0, 12'hB0B, 1'b1, 0);
    drive(0, 1, 4, 0, 1'b0, 1'b0, 12'h0B0, 1'b1, 1);
    blank(1, 0, 1);
    check("b2b_second_words", words_written, 2);
    check("b2b_second_state", state_dbg, CAP_CAPTURE);
    blank(1, 1, 0);
    blank(3, 0, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
